// File: rtl/avalon_dp_ram_pkg.sv
// Shared types and helpers for the dual-port on-chip RAM.
package avalon_dp_ram_pkg;

    typedef enum logic [0:0] {StClear, StRun} ram_state_e;

    // Legal read latency range; anything outside falls back to the minimum.
    localparam int unsigned MinReadLatency = 1;
    localparam int unsigned MaxReadLatency = 2;

    // Widest word the lane-merge helper handles.
    localparam int unsigned MaxDataW = 1024;
    localparam int unsigned MaxBeW   = MaxDataW / 8;

    function automatic bit read_latency_legal(int unsigned lat);
        return (lat >= MinReadLatency) && (lat <= MaxReadLatency);
    endfunction

    // Replace the byte lanes selected by be with the lanes of new_word.
    function automatic logic [MaxDataW-1:0] merge_lanes(logic [MaxDataW-1:0] old_word,
                                                        logic [MaxDataW-1:0] new_word,
                                                        logic [MaxBeW-1:0]   be);
        logic [MaxDataW-1:0] res;
        res = old_word;
        for (int i = 0; i < int'(MaxBeW); i++) begin
            if (be[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/avalon_dp_onchip_ram_if.sv
// Bus bundle for both RAM ports: s1 (Avalon-MM slave) and s2 (read-only datapath port).
interface avalon_dp_onchip_ram_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0]   s1_address;
    logic                s1_chipselect;
    logic                s1_read;
    logic                s1_write;
    logic [DATA_W/8-1:0] s1_byteenable;
    logic [DATA_W-1:0]   s1_writedata;
    logic                s1_clken;
    logic                s1_waitrequest;
    logic [DATA_W-1:0]   s1_readdata;
    logic                s1_readdatavalid;

    logic [ADDR_W-1:0]   s2_address;
    logic                s2_read;
    logic                s2_ready;
    logic [DATA_W-1:0]   s2_readdata;
    logic                s2_readdatavalid;

    modport master (
        output s1_address, s1_chipselect, s1_read, s1_write, s1_byteenable, s1_writedata,
        output s1_clken, s2_address, s2_read,
        input  s1_waitrequest, s1_readdata, s1_readdatavalid,
        input  s2_ready, s2_readdata, s2_readdatavalid
    );

    modport slave (
        input  s1_address, s1_chipselect, s1_read, s1_write, s1_byteenable, s1_writedata,
        input  s1_clken, s2_address, s2_read,
        output s1_waitrequest, s1_readdata, s1_readdatavalid,
        output s2_ready, s2_readdata, s2_readdatavalid
    );
endinterface

// File: rtl/ram_read_pipe.sv
// Read-return pipeline: LATENCY valid/data stages that freeze while hold is high.
module ram_read_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hold,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);
    logic [LATENCY-1:0] valid_q;
    logic [DATA_W-1:0]  data_q [LATENCY];

    // Advance stages unless held; data only moves with a valid beat so outputs hold when idle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < int'(LATENCY); i++) data_q[i] <= '0;
        end else if (!hold) begin
            valid_q[0] <= in_valid;
            if (in_valid) data_q[0] <= in_data;
            for (int i = 1; i < int'(LATENCY); i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) data_q[i] <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1] && !hold;
    assign out_data  = data_q[LATENCY-1];
endmodule

// File: rtl/avalon_dp_onchip_ram.sv
// Dual-port on-chip RAM: s1 Avalon-MM slave (byte enables, pipelined reads, clken stall)
// and s2 read-only port. Optional post-reset zero sweep.
// Define AVALON_DP_RAM_RDW_FORWARD_EN to forward s1 write data to a colliding s2 read.
module avalon_dp_onchip_ram
    import avalon_dp_ram_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned ADDR_W         = $clog2(DEPTH),
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input logic                   clk,
    input logic                   reset_n,
    avalon_dp_onchip_ram_if.slave bus
);
    localparam int unsigned BeW = DATA_W / 8;
    localparam int unsigned Lat = read_latency_legal(READ_LATENCY) ? READ_LATENCY : MinReadLatency;

    logic [DATA_W-1:0] mem [DEPTH];

    ram_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    logic              run;
    logic              s1_accept, s1_wr_acc, s1_rd_acc, s1_in_range, s1_hold;
    logic              s2_accept, s2_in_range;
    logic [DATA_W-1:0] s1_rd_word, s2_rd_word;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BeW-1:0]    mem_be;

    // State and clear-counter registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? StClear : StRun;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next state: sweep one word per cycle, leave CLEAR after the last word
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            StClear: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d   = StRun;
                    clr_cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    assign run                = reset_n && (state_q == StRun);
    assign bus.s1_waitrequest = !(run && bus.s1_clken);
    assign bus.s2_ready       = run;

    assign s1_accept   = bus.s1_chipselect && (bus.s1_read || bus.s1_write) && !bus.s1_waitrequest;
    assign s1_wr_acc   = s1_accept && bus.s1_write;
    // A combined read+write request is treated as a write only
    assign s1_rd_acc   = s1_accept && bus.s1_read && !bus.s1_write;
    assign s1_in_range = 32'(bus.s1_address) < DEPTH;
    assign s1_rd_word  = s1_in_range ? mem[bus.s1_address] : '0;
    assign s1_hold     = !bus.s1_clken;

    assign s2_accept   = bus.s2_read && bus.s2_ready;
    assign s2_in_range = 32'(bus.s2_address) < DEPTH;

`ifdef AVALON_DP_RAM_RDW_FORWARD_EN
    logic s2_collide;
    assign s2_collide = s1_wr_acc && s1_in_range && (bus.s2_address == bus.s1_address);
    assign s2_rd_word = !s2_in_range ? '0 :
                        s2_collide   ? DATA_W'(merge_lanes(MaxDataW'(mem[bus.s2_address]),
                                                           MaxDataW'(bus.s1_writedata),
                                                           MaxBeW'(bus.s1_byteenable))) :
                                       mem[bus.s2_address];
`else
    assign s2_rd_word = s2_in_range ? mem[bus.s2_address] : '0;
`endif

    // Single write port: the clear sweep owns it in CLEAR, otherwise accepted s1 writes
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.s1_address;
        mem_wdata = bus.s1_writedata;
        mem_be    = bus.s1_byteenable;
        if (reset_n && (state_q == StClear)) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
            mem_be    = '1;
        end else if (s1_wr_acc && s1_in_range) begin
            mem_we = 1'b1;
        end
    end

    // Array write with per-lane enables; contents are never reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < int'(BeW); i++) begin
                if (mem_be[i]) mem[mem_waddr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
            end
        end
    end

    ram_read_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (Lat)
    ) u_s1_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .hold      (s1_hold),
        .in_valid  (s1_rd_acc),
        .in_data   (s1_rd_word),
        .out_valid (bus.s1_readdatavalid),
        .out_data  (bus.s1_readdata)
    );

    ram_read_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (Lat)
    ) u_s2_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .hold      (1'b0),
        .in_valid  (s2_accept),
        .in_data   (s2_rd_word),
        .out_valid (bus.s2_readdatavalid),
        .out_data  (bus.s2_readdata)
    );
endmodule

// File: tb/tb_avalon_dp_onchip_ram.sv
// Bench for avalon_dp_onchip_ram: two instances (DEPTH 256 / latency 1 and DEPTH 200 /
// latency 2) driven by the same stimulus, each checked against a queue-based reference model.
module tb_avalon_dp_onchip_ram;
    localparam int unsigned DEPTH_A = 256;
    localparam int unsigned DEPTH_B = 200;
    localparam int unsigned LAT_A   = 1;
    localparam int unsigned LAT_B   = 2;
    localparam int unsigned DEP [2] = '{DEPTH_A, DEPTH_B};
    localparam int unsigned LAT [2] = '{LAT_A, LAT_B};

    typedef struct {
        logic [31:0] data;
        int          rem;
    } pend_t;

    logic        clk;
    logic        rst_n [2];
    logic        cs, rd, wr, clken, s2rd;
    logic [7:0]  addr, s2addr;
    logic [3:0]  be;
    logic [31:0] wdata;

    avalon_dp_onchip_ram_if #(.DATA_W(32), .ADDR_W(8)) bus0 ();
    avalon_dp_onchip_ram_if #(.DATA_W(32), .ADDR_W(8)) bus1 ();

    assign bus0.s1_address = addr;   assign bus1.s1_address = addr;
    assign bus0.s1_chipselect = cs;  assign bus1.s1_chipselect = cs;
    assign bus0.s1_read = rd;        assign bus1.s1_read = rd;
    assign bus0.s1_write = wr;       assign bus1.s1_write = wr;
    assign bus0.s1_byteenable = be;  assign bus1.s1_byteenable = be;
    assign bus0.s1_writedata = wdata; assign bus1.s1_writedata = wdata;
    assign bus0.s1_clken = clken;    assign bus1.s1_clken = clken;
    assign bus0.s2_address = s2addr; assign bus1.s2_address = s2addr;
    assign bus0.s2_read = s2rd;      assign bus1.s2_read = s2rd;

    logic        w [2], rdy [2], v1 [2], v2 [2];
    logic [31:0] r1 [2], r2 [2];
    assign w[0] = bus0.s1_waitrequest;   assign w[1] = bus1.s1_waitrequest;
    assign rdy[0] = bus0.s2_ready;       assign rdy[1] = bus1.s2_ready;
    assign v1[0] = bus0.s1_readdatavalid; assign v1[1] = bus1.s1_readdatavalid;
    assign v2[0] = bus0.s2_readdatavalid; assign v2[1] = bus1.s2_readdatavalid;
    assign r1[0] = bus0.s1_readdata;     assign r1[1] = bus1.s1_readdata;
    assign r2[0] = bus0.s2_readdata;     assign r2[1] = bus1.s2_readdata;

    avalon_dp_onchip_ram #(
        .DATA_W(32), .DEPTH(DEPTH_A), .READ_LATENCY(LAT_A), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clk(clk), .reset_n(rst_n[0]), .bus(bus0)
    );

    avalon_dp_onchip_ram #(
        .DATA_W(32), .DEPTH(DEPTH_B), .READ_LATENCY(LAT_B), .CLEAR_ON_RESET(1)
    ) dut_b (
        .clk(clk), .reset_n(rst_n[1]), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] mmem [2][256];
    pend_t       q1 [2][$];
    pend_t       q2 [2][$];
    int          clear_left [2];
    logic [31:0] last1 [2], last2 [2];

    // Per-cycle snapshots and beat logs for directed checks
    logic        snap_w [2], snap_v1 [2];
    logic [31:0] snap_r1 [2];
    logic [31:0] log1 [2][$];
    logic [31:0] log2 [2][$];

    int n_checks = 0;
    int n_errors = 0;
    bit checks_on = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge32(logic [31:0] o, logic [31:0] n, logic [3:0] m);
        logic [31:0] res;
        res = o;
        for (int i = 0; i < 4; i++) if (m[i]) res[i*8 +: 8] = n[i*8 +: 8];
        return res;
    endfunction

    task automatic check_outputs(input int d);
        logic ev1, ev2;
        ev1 = (q1[d].size() != 0) && (q1[d][0].rem == 0) && clken;
        ev2 = (q2[d].size() != 0) && (q2[d][0].rem == 0);
        check_eq($sformatf("d%0d waitrequest", d), 32'(w[d]),
                 32'(!rst_n[d] || clear_left[d] != 0 || !clken));
        check_eq($sformatf("d%0d s2_ready", d), 32'(rdy[d]),
                 32'(rst_n[d] && clear_left[d] == 0));
        check_eq($sformatf("d%0d s1_valid", d), 32'(v1[d]), 32'(ev1));
        check_eq($sformatf("d%0d s2_valid", d), 32'(v2[d]), 32'(ev2));
        if (ev1) begin
            check_eq($sformatf("d%0d s1_rdata", d), r1[d], q1[d][0].data);
            last1[d] = q1[d][0].data;
        end else if (q1[d].size() == 0) begin
            check_eq($sformatf("d%0d s1_rdata_hold", d), r1[d], last1[d]);
        end
        if (ev2) begin
            check_eq($sformatf("d%0d s2_rdata", d), r2[d], q2[d][0].data);
            last2[d] = q2[d][0].data;
        end else if (q2[d].size() == 0) begin
            check_eq($sformatf("d%0d s2_rdata_hold", d), r2[d], last2[d]);
        end
    endtask

    task automatic model_edge(input int d);
        pend_t       p;
        logic [31:0] w2;
        if (!rst_n[d]) begin
            clear_left[d] = int'(DEP[d]);
            q1[d].delete();
            q2[d].delete();
            last1[d] = '0;
            last2[d] = '0;
            return;
        end
        if (clear_left[d] != 0) begin
            clear_left[d]--;
            if (clear_left[d] == 0) for (int i = 0; i < int'(DEP[d]); i++) mmem[d][i] = '0;
            return;
        end
        if (clken) begin
            if (q1[d].size() != 0 && q1[d][0].rem == 0) void'(q1[d].pop_front());
            for (int i = 0; i < q1[d].size(); i++)
                if (q1[d][i].rem != 0) q1[d][i].rem = q1[d][i].rem - 1;
        end
        if (q2[d].size() != 0 && q2[d][0].rem == 0) void'(q2[d].pop_front());
        for (int i = 0; i < q2[d].size(); i++)
            if (q2[d][i].rem != 0) q2[d][i].rem = q2[d][i].rem - 1;
        if (s2rd) begin
            w2 = (32'(s2addr) < DEP[d]) ? mmem[d][s2addr] : 32'h0;
`ifdef AVALON_DP_RAM_RDW_FORWARD_EN
            if (cs && wr && clken && s2addr == addr && 32'(addr) < DEP[d])
                w2 = merge32(w2, wdata, be);
`endif
            p.data = w2;
            p.rem  = int'(LAT[d]) - 1;
            q2[d].push_back(p);
        end
        if (cs && clken && rd && !wr) begin
            p.data = (32'(addr) < DEP[d]) ? mmem[d][addr] : 32'h0;
            p.rem  = int'(LAT[d]) - 1;
            q1[d].push_back(p);
        end
        if (cs && clken && wr && 32'(addr) < DEP[d])
            mmem[d][addr] = merge32(mmem[d][addr], wdata, be);
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the model at the edge
    task automatic step();
        #2;
        for (int d = 0; d < 2; d++) begin
            if (checks_on) check_outputs(d);
            snap_w[d]  = w[d];
            snap_v1[d] = v1[d];
            snap_r1[d] = r1[d];
            if (v1[d]) log1[d].push_back(r1[d]);
            if (v2[d]) log2[d].push_back(r2[d]);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_edge(d);
        #1;
    endtask

    task automatic idle();
        cs = 1'b0; rd = 1'b0; wr = 1'b0; s2rd = 1'b0;
    endtask

    task automatic s1_write(input logic [7:0] a, input logic [3:0] m, input logic [31:0] dat);
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; be = m; wdata = dat;
        step();
        idle();
    endtask

    task automatic s1_read_expect(input logic [7:0] a, input logic [31:0] e0,
                                  input logic [31:0] e1);
        int          lat0, lat1;
        logic [31:0] dat0, dat1;
        lat0 = 0; lat1 = 0; dat0 = '0; dat1 = '0;
        cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
        step();
        idle();
        for (int k = 1; k <= 6; k++) begin
            step();
            if (snap_v1[0] && lat0 == 0) begin lat0 = k; dat0 = snap_r1[0]; end
            if (snap_v1[1] && lat1 == 0) begin lat1 = k; dat1 = snap_r1[1]; end
        end
        check_eq($sformatf("d0 latency @%0d", a), 32'(lat0), LAT_A);
        check_eq($sformatf("d0 data @%0d", a), dat0, e0);
        check_eq($sformatf("d1 latency @%0d", a), 32'(lat1), LAT_B);
        check_eq($sformatf("d1 data @%0d", a), dat1, e1);
    endtask

    initial begin
        int  c0, c1;
        bit  done0, done1;
        logic [31:0] exp_s2;

        idle();
        clken = 1'b1; addr = '0; s2addr = '0; be = '0; wdata = '0;
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        clear_left[0] = 0; clear_left[1] = 0;
        last1[0] = '0; last1[1] = '0; last2[0] = '0; last2[1] = '0;
        step();
        checks_on = 1'b1;
        step();
        step();

        // Clear sweep length; instance B gets reset again at clear count 100
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        c0 = 0; c1 = 0; done0 = 1'b0; done1 = 1'b0;
        for (int i = 0; i < 800 && !(done0 && done1); i++) begin
            rst_n[1] = (i != 100);
            step();
            if (!done0) begin if (snap_w[0]) c0++; else done0 = 1'b1; end
            if (i > 100 && !done1) begin if (snap_w[1]) c1++; else done1 = 1'b1; end
        end
        rst_n[1] = 1'b1;
        check_eq("d0 clear cycles", 32'(c0), DEPTH_A);
        check_eq("d1 clear cycles after restart", 32'(c1), DEPTH_B);

        s1_read_expect(8'd0, 32'h0, 32'h0);
        s1_read_expect(8'd17, 32'h0, 32'h0);
        s1_read_expect(8'd255, 32'h0, 32'h0);

        // Byte-lane write merge
        s1_write(8'd5, 4'hF, 32'hDEADBEEF);
        s1_write(8'd5, 4'h1, 32'h000000AA);
        s1_read_expect(8'd5, 32'hDEADBEAA, 32'hDEADBEAA);

        // Back-to-back reads with a 3-cycle clken stall mid-burst
        s1_write(8'd1, 4'hF, 32'h11);
        s1_write(8'd2, 4'hF, 32'h22);
        s1_write(8'd3, 4'hF, 32'h33);
        s1_write(8'd4, 4'hF, 32'h44);
        log1[0].delete(); log1[1].delete();
        cs = 1'b1; rd = 1'b1; wr = 1'b0;
        addr = 8'd1; step();
        addr = 8'd2; step();
        addr = 8'd3; clken = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("d0 stall waitrequest", 32'(snap_w[0]), 32'h1);
            check_eq("d1 stall waitrequest", 32'(snap_w[1]), 32'h1);
        end
        clken = 1'b1; step();
        addr = 8'd4; step();
        idle();
        for (int k = 0; k < 6; k++) step();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d burst beats", d), 32'(log1[d].size()), 32'd4);
            for (int k = 0; k < 4 && k < log1[d].size(); k++)
                check_eq($sformatf("d%0d burst beat %0d", d, k), log1[d][k], 32'((k + 1) * 17));
        end

        // s2 read colliding with an s1 write to the same word
        log2[0].delete(); log2[1].delete();
`ifdef AVALON_DP_RAM_RDW_FORWARD_EN
        exp_s2 = 32'h12345678;
`else
        exp_s2 = 32'h0;
`endif
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = 8'd9; be = 4'hF; wdata = 32'h12345678;
        s2rd = 1'b1; s2addr = 8'd9;
        step();
        idle();
        for (int k = 0; k < 4; k++) step();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d collide beats", d), 32'(log2[d].size()), 32'd1);
            if (log2[d].size() != 0)
                check_eq($sformatf("d%0d collide data", d), log2[d][0], exp_s2);
        end

        // Out-of-range write/read on the 200-word instance
        s1_write(8'd210, 4'hF, 32'hCAFEF00D);
        s1_read_expect(8'd210, 32'hCAFEF00D, 32'h0);
        s1_read_expect(8'd199, 32'h0, 32'h0);

        // Randomized traffic checked every cycle by the model
        for (int i = 0; i < 600; i++) begin
            cs     = ($urandom_range(3) != 0);
            rd     = $urandom_range(1);
            wr     = ($urandom_range(2) == 0);
            addr   = ($urandom_range(1) != 0) ? 8'(190 + $urandom_range(25)) : 8'($urandom);
            be     = 4'($urandom);
            wdata  = $urandom;
            clken  = ($urandom_range(4) != 0);
            s2rd   = $urandom_range(1);
            s2addr = ($urandom_range(1) != 0) ? addr : 8'($urandom);
            step();
        end
        idle();
        clken = 1'b1;
        for (int k = 0; k < 6; k++) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
